fir_alu_sequencer: RTL and testbench
====================================

// Module: fir_alu_sequencer
// PURPOSE
// - Initiator side of the FIR datapath ALU interface. It issues alu_op, src1 and src2 and consumes result and overflow.
// - Holds a NTAPS-deep sample history and NTAPS coefficients.
// - On each new sample it sequences MUL then ADD/SUB per tap to form the filtered output.
// - Sits between the SPI sample front end and the combinational ALU.
// PARAMETERS
// - NTAPS     4        number of filter taps (2..8)
// - NEG_MASK  4'b0000  bit i=1: tap i product is subtracted (SUB), else added (ADD)
// PORTS
// - clk           in   1   system clock, rising edge
// - n_rst         in   1   asynchronous reset, active low
// - data_ready    in   1   one-cycle pulse: sample_data valid
// - sample_data   in   16  unsigned sample
// - coef_load     in   1   write coef_data into coefficient coef_idx
// - coef_idx      in   3   coefficient index (< NTAPS)
// - coef_data     in   16  coefficient, unsigned Q1.15 (0x8000 = 1.0)
// - busy          out  1   sequence in progress
// - alu_op        out  2   PASS=0 ADD=1 SUB=2 MUL=3
// - alu_src1      out  17  signed ALU operand 1
// - alu_src2      out  17  signed ALU operand 2
// - alu_result    in   17  signed ALU result, combinational from current ops
// - alu_overflow  in   1   ALU overflow, combinational
// - fir_out       out  16  filtered result
// - out_valid     out  1   one-cycle pulse: fir_out updated
// - err           out  1   sticky error, cleared by next accepted data_ready
// BEHAVIOUR
// - Reset (async, n_rst=0): state IDLE; samples, coefs, acc, prod = 0; all outputs 0 (alu_op=PASS).
// - FSM: IDLE -> SHIFT -> {MUL -> ACC} x NTAPS -> DONE -> IDLE.
//   - IDLE: data_ready=1 -> SHIFT. Sample shifts into history[0] and the oldest sample drops. err cleared.
//   - SHIFT: one cycle. acc<=0, tap index i<=0.
//   - MUL: alu_op=MUL, src1={1'b0,hist[i]}, src2={1'b0,coef[i]}; prod<=alu_result at cycle end.
//   - ACC: alu_op=NEG_MASK[i]?SUB:ADD, src1=acc, src2=prod; acc<=alu_result.
//     i==NTAPS-1 -> DONE, else i++ -> MUL.
//   - DONE: fir_out<=acc[15:0], out_valid=1 for this cycle. err|=acc[16] (negative result); fir_out=0 if negative.
// - ALU outputs are registered the same cycle they are driven (ALU is combinational).
// - Latency: data_ready to out_valid = 2*NTAPS+2 cycles; busy=1 in all states but IDLE.
// - alu_overflow=1 in any MUL or ACC cycle sets err; the sequence completes regardless.
// - Boundary conditions:
//   - data_ready while busy: sample dropped, err<=1.
//   - coef_load while busy: ignored.
//   - coef_idx>=NTAPS: ignored.
//   - coef_load and data_ready together in IDLE: both take effect; the new coef is used this sequence.
// - Reset mid-sequence: immediate return to reset values; no out_valid.
// CONFIGURATION
// - FIR_SEQ_SATURATE_EN defined: on alu_overflow in ACC, acc<=17'sh0FFFF (ADD) or 17'sh00000 (SUB).
// - FIR_SEQ_SATURATE_EN undefined: acc takes the wrapped alu_result.
// - err is set in both cases.
// STRUCTURE
// - fir_pkg:
//   - typedef enum logic[1:0] alu_op_t {PASS,ADD,SUB,MUL} (shared with the ALU).
//   - typedef enum seq_state_t {IDLE,SHIFT,MUL,ACC,DONE}.
//   - localparam MAX_TAPS=8.
// - Sub-module fir_tap_regs: sample shift history plus coefficient register file.
//   - Exposes hist[i]/coef[i] by index.
// - The FSM, acc/prod registers and ALU operand muxing stay in fir_alu_sequencer.
// TESTING
// - All coefs 0x8000, NEG_MASK=0; samples 100 then 200 -> fir_out=100 then 300.
//   - out_valid 10 cycles after each data_ready; err=0.
// - NEG_MASK=4'b0010, coefs 0x8000; samples 100, 200 -> second fir_out=100.
// - coefs 0x8000; samples 0xFFFF, 0xFFFF -> ACC overflow, err=1.
//   - Without FIR_SEQ_SATURATE_EN: fir_out=0xFFFE.
//   - With FIR_SEQ_SATURATE_EN: fir_out=0xFFFF.
// - coef[0]=0xFFFF, sample 0xFFFF -> MUL overflow, err=1, out_valid still pulses.
// - data_ready 3 cycles after a prior data_ready -> err=1, second sample not in history, first output unchanged.
// - Assert n_rst during ACC -> all outputs 0 asynchronously; no out_valid; the next data_ready runs a normal sequence.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types for the FIR sequencer and its combinational ALU.
package fir_pkg;

  localparam int MAX_TAPS = 8;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2,
    MUL  = 2'd3
  } alu_op_t;

  // State literals carry a prefix because MUL is already an ALU opcode name.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_MUL   = 3'd2,
    ST_ACC   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fir_alu_sequencer_if.sv
// Operand/result bundle between the FIR sequencer (master) and the ALU (slave).
interface fir_alu_sequencer_if;
  import fir_pkg::*;

  // No valid/ready pair: the ALU is purely combinational, so alu_result and
  // alu_overflow are valid in the same cycle the operands and opcode are driven.
  alu_op_t            alu_op;
  logic signed [16:0] alu_src1;
  logic signed [16:0] alu_src2;
  logic signed [16:0] alu_result;
  logic               alu_overflow;

  modport master (output alu_op, alu_src1, alu_src2, input alu_result, alu_overflow);
  modport slave  (input alu_op, alu_src1, alu_src2, output alu_result, alu_overflow);

endinterface

// File: rtl/fir_tap_regs.sv
// Sample history shift register and coefficient register file, read by tap index.
module fir_tap_regs
  import fir_pkg::*;
#(
  parameter int NTAPS = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        shift_en,
  input  logic [15:0] shift_data,
  input  logic        coef_we,
  input  logic [2:0]  coef_idx,
  input  logic [15:0] coef_data,
  input  logic [2:0]  rd_idx,
  output logic [15:0] hist_rd,
  output logic [15:0] coef_rd
);

  // Sized to MAX_TAPS so any 3-bit index is in range; entries >= NTAPS stay 0.
  logic [15:0] r_hist [MAX_TAPS];
  logic [15:0] r_coef [MAX_TAPS];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < MAX_TAPS; k++) begin
        r_hist[k] <= '0;
        r_coef[k] <= '0;
      end
    end else begin
      if (shift_en) begin
        r_hist[0] <= shift_data;
        for (int k = 1; k < NTAPS; k++) r_hist[k] <= r_hist[k-1];
      end
      if (coef_we && (int'(coef_idx) < NTAPS)) r_coef[coef_idx] <= coef_data;
    end
  end

  assign hist_rd = r_hist[rd_idx];
  assign coef_rd = r_coef[rd_idx];

endmodule

// File: rtl/fir_alu_sequencer.sv
// FIR tap sequencer driving an external combinational ALU: MUL then ADD/SUB per tap.
// Optional FIR_SEQ_SATURATE_EN: saturate the accumulator on ACC overflow instead of wrapping.
module fir_alu_sequencer
  import fir_pkg::*;
#(
  parameter int                  NTAPS    = 4,
  parameter logic [MAX_TAPS-1:0] NEG_MASK = '0
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       data_ready,
  input  logic [15:0]                sample_data,
  input  logic                       coef_load,
  input  logic [2:0]                 coef_idx,
  input  logic [15:0]                coef_data,
  output logic                       busy,
  fir_alu_sequencer_if.master        alu,
  output logic [15:0]                fir_out,
  output logic                       out_valid,
  output logic                       err,
  output seq_state_t                 dbg_state
);

  localparam logic [2:0] LAST_TAP = 3'(NTAPS - 1);

  seq_state_t         r_state, w_next_state;
  logic [2:0]         r_tap;
  logic signed [16:0] r_acc;
  logic signed [16:0] r_prod;
  logic [15:0]        r_fir_out;
  logic               r_err;
  logic               r_ovf;

  logic [15:0]        w_hist;
  logic [15:0]        w_coef;
  logic               w_idle_accept;
  logic signed [16:0] w_acc_next;
  logic [15:0]        w_fir_done;

  assign w_idle_accept = (r_state == ST_IDLE) && data_ready;

  fir_tap_regs #(.NTAPS(NTAPS)) u_tap_regs (
    .clk        (clk),
    .n_rst      (n_rst),
    .shift_en   (w_idle_accept),
    .shift_data (sample_data),
    .coef_we    (coef_load && (r_state == ST_IDLE)),
    .coef_idx   (coef_idx),
    .coef_data  (coef_data),
    .rd_idx     (r_tap),
    .hist_rd    (w_hist),
    .coef_rd    (w_coef)
  );

  always_comb begin
    w_next_state = r_state;
    alu.alu_op   = PASS;
    alu.alu_src1 = '0;
    alu.alu_src2 = '0;
    case (r_state)
      ST_IDLE:  if (data_ready) w_next_state = ST_SHIFT;
      ST_SHIFT: w_next_state = ST_MUL;
      ST_MUL: begin
        alu.alu_op   = MUL;
        alu.alu_src1 = {1'b0, w_hist};
        alu.alu_src2 = {1'b0, w_coef};
        w_next_state = ST_ACC;
      end
      ST_ACC: begin
        alu.alu_op   = NEG_MASK[r_tap] ? SUB : ADD;
        alu.alu_src1 = r_acc;
        alu.alu_src2 = r_prod;
        w_next_state = (r_tap == LAST_TAP) ? ST_DONE : ST_MUL;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

`ifdef FIR_SEQ_SATURATE_EN
  assign w_acc_next = !alu.alu_overflow ? alu.alu_result :
                      (NEG_MASK[r_tap] ? 17'sh00000 : 17'sh0FFFF);
`else
  assign w_acc_next = alu.alu_result;
`endif

  // A wrapped accumulator's sign bit is meaningless, so only a clean negative sum clamps to 0.
  assign w_fir_done = (r_acc[16] && !r_ovf) ? 16'h0000 : r_acc[15:0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= ST_IDLE;
      r_tap     <= '0;
      r_acc     <= '0;
      r_prod    <= '0;
      r_fir_out <= '0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: if (data_ready) r_err <= 1'b0;
        ST_SHIFT: begin
          r_acc <= '0;
          r_tap <= '0;
          r_ovf <= 1'b0;
        end
        ST_MUL: begin
          r_prod <= alu.alu_result;
          if (alu.alu_overflow) begin
            r_err <= 1'b1;
            r_ovf <= 1'b1;
          end
        end
        ST_ACC: begin
          r_acc <= w_acc_next;
          if (alu.alu_overflow) begin
            r_err <= 1'b1;
            r_ovf <= 1'b1;
          end
          if (r_tap != LAST_TAP) r_tap <= r_tap + 3'd1;
        end
        ST_DONE: begin
          r_fir_out <= w_fir_done;
          if (r_acc[16]) r_err <= 1'b1;
        end
        default: ;
      endcase
      if (data_ready && (r_state != ST_IDLE)) r_err <= 1'b1;
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign fir_out   = (r_state == ST_DONE) ? w_fir_done : r_fir_out;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fir_alu_sequencer.sv
// Directed bench for fir_alu_sequencer: two instances (NEG_MASK 0 and 0010) each with an ALU model.
module tb_fir_alu_sequencer;
  import fir_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (NEG_MASK = 0) ----------------
  logic        a_dr = 0, a_cl = 0;
  logic [15:0] a_sd = 0, a_cd = 0;
  logic [2:0]  a_ci = 0;
  logic        a_busy, a_ov, a_err;
  logic [15:0] a_fir;
  seq_state_t  a_state;
  fir_alu_sequencer_if a_if ();

  fir_alu_sequencer #(.NTAPS(4), .NEG_MASK(8'b0000_0000)) u_dut_a (
    .clk(clk), .n_rst(n_rst), .data_ready(a_dr), .sample_data(a_sd),
    .coef_load(a_cl), .coef_idx(a_ci), .coef_data(a_cd), .busy(a_busy),
    .alu(a_if), .fir_out(a_fir), .out_valid(a_ov), .err(a_err), .dbg_state(a_state)
  );

  // ---------------- DUT B (NEG_MASK = 0010) ----------------
  logic        b_dr = 0, b_cl = 0;
  logic [15:0] b_sd = 0, b_cd = 0;
  logic [2:0]  b_ci = 0;
  logic        b_busy, b_ov, b_err;
  logic [15:0] b_fir;
  seq_state_t  b_state;
  fir_alu_sequencer_if b_if ();

  fir_alu_sequencer #(.NTAPS(4), .NEG_MASK(8'b0000_0010)) u_dut_b (
    .clk(clk), .n_rst(n_rst), .data_ready(b_dr), .sample_data(b_sd),
    .coef_load(b_cl), .coef_idx(b_ci), .coef_data(b_cd), .busy(b_busy),
    .alu(b_if), .fir_out(b_fir), .out_valid(b_ov), .err(b_err), .dbg_state(b_state)
  );

  // ALU model: 17-bit signed; MUL is a Q1.15 product (shift right 15); overflow = result out of 17-bit range.
  function automatic logic [17:0] alu_f(input logic [1:0] op, input logic signed [16:0] a,
                                        input logic signed [16:0] b);
    logic signed [35:0] ea, eb, w;
    ea = a;
    eb = b;
    case (op)
      2'd1:    w = ea + eb;
      2'd2:    w = ea - eb;
      2'd3:    w = (ea * eb) >>> 15;
      default: w = ea;
    endcase
    return {(w[35:16] != {20{w[16]}}), w[16:0]};
  endfunction

  assign {a_if.alu_overflow, a_if.alu_result} = alu_f(a_if.alu_op, a_if.alu_src1, a_if.alu_src2);
  assign {b_if.alu_overflow, b_if.alu_result} = alu_f(b_if.alu_op, b_if.alu_src1, b_if.alu_src2);

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_pulses();
    a_dr = 0; a_cl = 0; b_dr = 0; b_cl = 0;
  endtask

  // Called at a falling edge; the pulse is released at the next falling edge.
  task automatic drive_sample(input bit sel, input logic [15:0] s);
    if (sel) begin b_dr = 1; b_sd = s; end
    else     begin a_dr = 1; a_sd = s; end
  endtask

  task automatic load_coef(input bit sel, input logic [2:0] idx, input logic [15:0] d);
    @(negedge clk);
    if (sel) begin b_cl = 1; b_ci = idx; b_cd = d; end
    else     begin a_cl = 1; a_ci = idx; a_cd = d; end
    @(negedge clk);
    clear_pulses();
  endtask

  task automatic load_all(input bit sel, input logic [15:0] d);
    for (int k = 0; k < 4; k++) load_coef(sel, 3'(k), d);
  endtask

  // Counts falling edges from the data_ready edge until out_valid; start = edges already consumed.
  task automatic wait_out(input bit sel, input string tag, input int start,
                          input bit chk_out, input logic exp_err);
    int          cyc;
    logic        seen;
    logic [15:0] exp;
    logic [15:0] got;
    cyc  = start;
    seen = 1'b0;
    got  = '0;
    while (!seen && cyc < start + 40) begin
      @(negedge clk);
      cyc++;
      clear_pulses();
      seen = sel ? b_ov : a_ov;
      got  = sel ? b_fir : a_fir;
    end
    check({tag, "_latency"}, seen ? cyc : 0, 10);
    exp = '0;
    if (chk_out) begin
      exp = exp_q.pop_front();
      if (seen) check({tag, "_fir_out"}, got, exp);
    end
    @(negedge clk);
    check({tag, "_err"}, sel ? b_err : a_err, exp_err);
    check({tag, "_valid_one_cycle"}, sel ? b_ov : a_ov, 0);
    if (chk_out) check({tag, "_fir_hold"}, sel ? b_fir : a_fir, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ov_cnt;
    repeat (2) @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_out_valid", a_ov, 0);
    check("rst_fir_out", a_fir, 0);
    check("rst_err", a_err, 0);
    check("rst_alu_op", a_if.alu_op, PASS);
    check("rst_state", a_state, ST_IDLE);
    n_rst = 1;

    load_all(0, 16'h8000);

    // Sample 100 with a look inside the first MUL cycle.
    drive_sample(0, 16'd100);
    exp_q.push_back(16'd100);
    @(negedge clk);
    clear_pulses();
    check("shift_busy", a_busy, 1);
    check("shift_state", a_state, ST_SHIFT);
    @(negedge clk);
    check("mul_op", a_if.alu_op, MUL);
    check("mul_src1", a_if.alu_src1, 32'd100);
    check("mul_src2", a_if.alu_src2, 32'h8000);
    wait_out(0, "s100", 2, 1, 0);

    drive_sample(0, 16'd200);
    exp_q.push_back(16'd300);
    wait_out(0, "s200", 0, 1, 0);

    // data_ready and coef_load while busy: both dropped, err raised.
    drive_sample(0, 16'd50);
    exp_q.push_back(16'd350);
    repeat (3) begin
      @(negedge clk);
      clear_pulses();
    end
    a_dr = 1; a_sd = 16'd999; a_cl = 1; a_ci = 3'd0; a_cd = 16'h0000;
    wait_out(0, "busy_drop", 3, 1, 1);

    // History must be 10,50,200,100 (999 absent) and coef0 unchanged.
    drive_sample(0, 16'd10);
    exp_q.push_back(16'd360);
    wait_out(0, "after_drop", 0, 1, 0);

    // coef_load with data_ready in IDLE: coef3=0 used in this very sequence.
    a_cl = 1; a_ci = 3'd3; a_cd = 16'h0000;
    drive_sample(0, 16'd20);
    exp_q.push_back(16'd80);
    wait_out(0, "coef_with_data", 0, 1, 0);

    // Out-of-range index must not alias onto coef0.
    load_coef(0, 3'd4, 16'h0000);
    drive_sample(0, 16'd30);
    exp_q.push_back(16'd60);
    wait_out(0, "coef_idx_oor", 0, 1, 0);

    // Instance B: tap 1 subtracted.
    load_all(1, 16'h8000);
    drive_sample(1, 16'd100);
    exp_q.push_back(16'd100);
    wait_out(1, "neg_s100", 0, 1, 0);
    drive_sample(1, 16'd200);
    exp_q.push_back(16'd100);
    wait_out(1, "neg_s200", 0, 1, 0);
    drive_sample(1, 16'd0);
    exp_q.push_back(16'd0);
    wait_out(1, "neg_result", 0, 1, 1);

    // Reset asserted during ACC.
    drive_sample(0, 16'd100);
    repeat (3) begin
      @(negedge clk);
      clear_pulses();
    end
    check("pre_rst_state", a_state, ST_ACC);
    #1 n_rst = 0;
    #1;
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_out_valid", a_ov, 0);
    check("mid_rst_fir_out", a_fir, 0);
    check("mid_rst_alu_op", a_if.alu_op, PASS);
    check("mid_rst_src1", a_if.alu_src1, 0);
    check("mid_rst_state", a_state, ST_IDLE);
    ov_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (a_ov) ov_cnt++;
      if (k == 2) n_rst = 1;
    end
    check("mid_rst_no_valid", ov_cnt, 0);

    // Normal sequence after reset, then ACC overflow.
    load_all(0, 16'h8000);
    drive_sample(0, 16'hFFFF);
    exp_q.push_back(16'hFFFF);
    wait_out(0, "post_rst_ffff", 0, 1, 0);
    drive_sample(0, 16'hFFFF);
`ifdef FIR_SEQ_SATURATE_EN
    exp_q.push_back(16'hFFFF);
`else
    exp_q.push_back(16'hFFFE);
`endif
    wait_out(0, "acc_ovf", 0, 1, 1);

    // MUL overflow: coef0 = 0xFFFF on a fresh history.
    @(negedge clk);
    n_rst = 0;
    @(negedge clk);
    n_rst = 1;
    load_coef(0, 3'd0, 16'hFFFF);
    for (int k = 1; k < 4; k++) load_coef(0, 3'(k), 16'h8000);
    drive_sample(0, 16'hFFFF);
    wait_out(0, "mul_ovf", 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
